mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Load/store sequencer for the MEM stage of the MIPS32 pipeline.
- Accepts one memory op at a time from EX/MEM, checks alignment, and drives the SRAM-like data bus (split address/data handshake).
- Stalls the pipeline until the op completes, then extends load data per LB/LBU/LH/LHU/LW rules and returns it with a one-cycle response pulse.
- Raises AdEL/AdES instead of accessing the bus on misaligned addresses.

Parameters:
- ADDR_W, 32, width of virtual/physical address
- DATA_W, 32, bus data width (fixed at 32; parameter exists for lint only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM stage holds a load/store; held stable while stall=1
- req_wr  in  1  1=store, 0=load
- req_func  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; stores use 000/010/100 for SB/SH/SW
- req_addr  in  32  effective address
- req_wdata  in  32  store data (low bits significant)
- flush  in  1  exception/eret flush from CP0
- stall  out  1  holds pipeline while op in flight
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result, valid with resp_valid
- exc_adel  out  1  load address error, valid with resp_valid
- exc_ades  out  1  store address error, valid with resp_valid
- badvaddr  out  32  faulting address, valid with exc_*
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  0=byte, 1=half, 2=word
- data_addr  out  32  bus address (unmodified req_addr)
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte enables for stores, 0 for loads
- data_addr_ok  in  1  bus accepted address
- data_data_ok  in  1  read data ready / write complete
- data_rdata  in  32  bus read data

Behaviour:
- States: IDLE, ADDR, DATA, DONE, DRAIN. Reset → IDLE. On reset all outputs are 0 (stall, resp_valid, exc_*, data_req, data_wstrb, resp_rdata, badvaddr).
- stall = req_valid & ~resp_valid & ~flush (combinational). The pipeline advances in the DONE cycle.
- Misaligned means: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. Byte ops are never misaligned.
- IDLE, req_valid, no flush:
  - Misaligned: go to DONE with exc_adel (load) or exc_ades (store) and badvaddr=req_addr. No bus request is made.
  - Aligned: go to ADDR and latch op, addr, wdata.
- ADDR: data_req=1 with all bus fields registered and stable.
  - data_addr_ok=1: go to DATA and drop data_req that same edge.
  - flush=1 and no data_addr_ok: go to IDLE (request withdrawn).
  - flush and data_addr_ok together: go to DRAIN.
- DATA: wait for data_data_ok, then go to DONE and latch the extended result. flush while in DATA: go to DRAIN.
- DRAIN: wait for data_data_ok, discard the data, go to IDLE. Never pulses resp_valid.
- DONE: resp_valid=1 for exactly 1 cycle, then IDLE. A new request is accepted the following cycle.
- flush in DONE suppresses resp_valid and the exc_* pulses.
- data_data_ok arriving in the same cycle as data_addr_ok is legal. It moves ADDR→DATA only; the bus never returns data_ok in the addr_ok cycle.
- Minimum load latency: accept cycle N, data_req in N+1. With addr_ok in N+1 and data_ok in N+2, resp_valid is in N+3.
- Load extension, by byte lane = addr[1:0]:
  - LB sign-extends the selected byte; LBU zero-extends it.
  - LH/LHU take the half at addr[1] (0→[15:0], 1→[31:16]).
  - LW passes data through.
- Stores:
  - SB: data_wdata = {4{wdata[7:0]}}, data_wstrb = 1<<addr[1:0].
  - SH: data_wdata = {2{wdata[15:0]}}, data_wstrb = addr[1] ? 1100 : 0011.
  - SW: data_wstrb = 1111.
  - Store resp_rdata = 0.
- data_size: byte ops 0, half 1, word 2.
- req_func values 101–111: treat as LW/SW.

Test Plan:
- LB, addr=0x1003, rdata=0x80AA55CC, addr_ok and data_ok one cycle apart → data_req for 1 cycle, size=0, resp_rdata=0xFFFFFF80, resp_valid 3 cycles after accept.
- LHU, addr=0x2002, rdata=0x9234ABCD → resp_rdata=0x00009234. LH at the same address → 0xFFFF9234.
- SB, addr=0x3001, wdata=0x000000A5 → data_wr=1, data_wdata=0xA5A5A5A5, wstrb=0010, size=0, resp_rdata=0.
- LW, addr=0x4002 → no data_req, resp_valid with exc_adel=1, badvaddr=0x4002. SH, addr=0x4001 → exc_ades=1.
- LW with addr_ok held low 5 cycles → stall high throughout, data_req/addr stable. Assert flush in cycle 3 → data_req drops next cycle, no resp_valid.
- Flush one cycle after addr_ok accepted, data_ok 4 cycles later → DRAIN, no resp_valid. A new LW issued afterwards completes with correct data. Reset mid-DATA → all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: alignment check, split addr/data bus
// handshake, load extension and a one-cycle completion pulse.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [2:0]        req_func,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t state;
  logic   resp_q;
  logic   adel_q;
  logic   ades_q;
  logic   uns_q;

  logic              is_word;
  logic              is_half;
  logic              mis;
  logic [1:0]        size;
  logic [3:0]        st_strb;
  logic [DATA_W-1:0] st_data;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] ld_ext;

  // func 1xx (incl. undefined 101-111) is a word access
  assign is_word = req_func[2];
  assign is_half = ~req_func[2] & req_func[1];
  assign mis = (is_word & |req_addr[1:0])
             | (is_half & req_addr[0]);

  always_comb begin
    size    = 2'd0;
    st_strb = 4'b0001 << req_addr[1:0];
    st_data = {4{req_wdata[7:0]}};
    unique case (1'b1)
      is_word: begin
        size    = 2'd2;
        st_strb = 4'b1111;
        st_data = req_wdata;
      end
      is_half: begin
        size    = 2'd1;
        st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = 8'h00;
    unique case (data_addr[1:0])
      2'd0: lane_b = data_rdata[7:0];
      2'd1: lane_b = data_rdata[15:8];
      2'd2: lane_b = data_rdata[23:16];
      2'd3: lane_b = data_rdata[31:24];
    endcase
    lane_h = data_addr[1] ? data_rdata[31:16]
                          : data_rdata[15:0];
    ld_ext = data_rdata;
    unique case (data_size)
      2'd2: ld_ext = data_rdata;
      2'd1: ld_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ld_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      resp_q     <= 1'b0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      uns_q      <= 1'b0;
      resp_rdata <= '0;
      badvaddr   <= '0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= 4'b0000;
    end else begin
      resp_q <= 1'b0;
      adel_q <= 1'b0;
      ades_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid && !flush) begin
            if (mis) begin
              state      <= S_DONE;
              resp_q     <= 1'b1;
              adel_q     <= ~req_wr;
              ades_q     <= req_wr;
              badvaddr   <= req_addr;
              resp_rdata <= '0;
            end else begin
              state      <= S_ADDR;
              data_req   <= 1'b1;
              data_wr    <= req_wr;
              data_size  <= size;
              data_addr  <= req_addr;
              data_wdata <= st_data;
              data_wstrb <= req_wr ? st_strb : 4'b0000;
              uns_q      <= req_func[0];
            end
          end
        end
        S_ADDR: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= flush ? S_DRAIN : S_DATA;
          end else if (flush) begin
            data_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_DATA: begin
          // data landing with the flush needs no drain
          if (data_data_ok) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              state      <= S_DONE;
              resp_q     <= 1'b1;
              resp_rdata <= data_wr ? '0 : ld_ext;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (data_data_ok) state <= S_IDLE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_q & ~flush;
  assign exc_adel   = adel_q & ~flush;
  assign exc_ades   = ades_q & ~flush;
  assign stall      = ~rst & req_valid & ~resp_valid & ~flush;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table, hand-written corner sequences
// and randomized ops against a transaction-level reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_wr;
  logic [2:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] badvaddr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr),
    .req_func(req_func), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .badvaddr(badvaddr),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rd;
    logic        adel;
    logic        ades;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [1:0]  size;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic wr, input logic [2:0] func,
    input logic [31:0] addr, wdata, rdata, rd,
    input logic adel, ades,
    input logic [31:0] wd, input logic [3:0] strb,
    input logic [1:0] size);
    vec_t v;
    v.wr = wr; v.func = func; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.rd = rd;
    v.adel = adel; v.ades = ades; v.wd = wd;
    v.strb = strb; v.size = size;
    return v;
  endfunction

  // Reference: access width from func, lanes by address arithmetic
  function automatic vec_t model(
    input logic wr, input logic [2:0] func,
    input logic [31:0] addr, wdata, rdata);
    vec_t m;
    int bytes, sh;
    logic [31:0] bv, hv;
    logic mis;
    bytes = func[2] ? 4 : (func[1] ? 2 : 1);
    sh = int'(addr % 4);
    mis = (addr % bytes) != 0;
    m.wr = wr; m.func = func; m.addr = addr;
    m.wdata = wdata; m.rdata = rdata;
    m.size = (bytes == 4) ? 2'd2 : (bytes == 2) ? 2'd1 : 2'd0;
    m.adel = mis && !wr;
    m.ades = mis && wr;
    bv = (rdata >> (8 * sh)) & 32'hFF;
    hv = (rdata >> (8 * (sh - sh % 2))) & 32'hFFFF;
    if (wr || mis) m.rd = 0;
    else if (bytes == 4) m.rd = rdata;
    else if (bytes == 2)
      m.rd = (func[0] || hv < 32'h8000) ? hv : hv - 32'h10000;
    else
      m.rd = (func[0] || bv < 32'h80) ? bv : bv - 32'h100;
    if (bytes == 4) m.wd = wdata;
    else if (bytes == 2) m.wd = (wdata & 32'hFFFF) * 32'h10001;
    else m.wd = (wdata & 32'hFF) * 32'h01010101;
    m.strb = wr ? 4'(((1 << bytes) - 1) << (sh - sh % bytes)) : 4'h0;
    return m;
  endfunction

  task automatic bus_idle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
  endtask

  task automatic set_req(input logic wr, input logic [2:0] func,
                         input logic [31:0] addr, wdata);
    req_valid = 1'b1;
    req_wr    = wr;
    req_func  = func;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // One op with bus latencies; dup raises data_ok with addr_ok,
  // fl_done flushes in the completion cycle
  task automatic do_op(input vec_t v, input int a_lat,
                       input int d_lat, input bit dup,
                       input bit fl_done);
    int phase, rc, dc, nreq, exp_lat;
    bit mis;
    mis = v.adel || v.ades;
    exp_lat = mis ? 1 : a_lat + d_lat + 3;
    phase = 0; rc = 0; dc = 0; nreq = 0;
    @(negedge clk);
    set_req(v.wr, v.func, v.addr, v.wdata);
    flush = 1'b0;
    bus_idle();
    #1 chk("accept_stall", 32'(stall), 32'd1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus_idle();
      if (phase == 0 && data_req) begin
        if (rc == a_lat) begin
          data_addr_ok = 1'b1;
          phase = 1;
          if (dup) data_data_ok = 1'b1;
        end
        rc++;
      end else if (phase == 1) begin
        if (dc == d_lat) begin
          data_data_ok = 1'b1;
          data_rdata = v.rdata;
          phase = 2;
        end
        dc++;
      end
      if (fl_done && cyc == exp_lat) flush = 1'b1;
      #1;
      if (data_req) begin
        nreq++;
        chk("bus_addr", data_addr, v.addr);
        chk("bus_wr", 32'(data_wr), 32'(v.wr));
        chk("bus_size", 32'(data_size), 32'(v.size));
        chk("bus_wstrb", 32'(data_wstrb), 32'(v.strb));
        if (v.wr) chk("bus_wdata", data_wdata, v.wd);
      end
      if (resp_valid || cyc == exp_lat) begin
        chk("resp_lat", cyc, exp_lat);
        chk("resp_valid", 32'(resp_valid), 32'(!fl_done));
        chk("exc_adel", 32'(exc_adel), 32'(v.adel && !fl_done));
        chk("exc_ades", 32'(exc_ades), 32'(v.ades && !fl_done));
        if (!fl_done && mis) chk("badvaddr", badvaddr, v.addr);
        if (!fl_done && !mis) chk("resp_rdata", resp_rdata, v.rd);
        break;
      end
      chk("busy_stall", 32'(stall), 32'd1);
    end
    chk("req_cycles", nreq, mis ? 0 : a_lat + 1);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    bus_idle();
    #1;
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
  endtask

  vec_t tbl[15];
  vec_t rv;
  logic rw;
  logic [2:0] rf;

  initial begin
    tbl[0]  = mkv(0, 3'd0, 32'h1003, 0, 32'h80AA55CC,
                  32'hFFFFFF80, 0, 0, 0, 4'h0, 2'd0);
    tbl[1]  = mkv(0, 3'd3, 32'h2002, 0, 32'h9234ABCD,
                  32'h00009234, 0, 0, 0, 4'h0, 2'd1);
    tbl[2]  = mkv(0, 3'd2, 32'h2002, 0, 32'h9234ABCD,
                  32'hFFFF9234, 0, 0, 0, 4'h0, 2'd1);
    tbl[3]  = mkv(1, 3'd0, 32'h3001, 32'h000000A5, 0,
                  32'h0, 0, 0, 32'hA5A5A5A5, 4'b0010, 2'd0);
    tbl[4]  = mkv(0, 3'd4, 32'h4002, 0, 0,
                  32'h0, 1, 0, 0, 4'h0, 2'd2);
    tbl[5]  = mkv(1, 3'd2, 32'h4001, 0, 0,
                  32'h0, 0, 1, 0, 4'h0, 2'd1);
    tbl[6]  = mkv(0, 3'd4, 32'h5000, 0, 32'h12345678,
                  32'h12345678, 0, 0, 0, 4'h0, 2'd2);
    tbl[7]  = mkv(1, 3'd4, 32'h6004, 32'hDEADBEEF, 0,
                  32'h0, 0, 0, 32'hDEADBEEF, 4'hF, 2'd2);
    tbl[8]  = mkv(0, 3'd1, 32'h1002, 0, 32'h80AA55CC,
                  32'h000000AA, 0, 0, 0, 4'h0, 2'd0);
    tbl[9]  = mkv(1, 3'd2, 32'h7002, 32'h1234BEEF, 0,
                  32'h0, 0, 0, 32'hBEEFBEEF, 4'b1100, 2'd1);
    tbl[10] = mkv(0, 3'd5, 32'h8000, 0, 32'hCAFEBABE,
                  32'hCAFEBABE, 0, 0, 0, 4'h0, 2'd2);
    tbl[11] = mkv(0, 3'd0, 32'h1000, 0, 32'h80AA557F,
                  32'h0000007F, 0, 0, 0, 4'h0, 2'd0);
    tbl[12] = mkv(1, 3'd6, 32'h800A, 0, 0,
                  32'h0, 0, 1, 0, 4'h0, 2'd2);
    tbl[13] = mkv(0, 3'd2, 32'h2001, 0, 0,
                  32'h0, 1, 0, 0, 4'h0, 2'd1);
    tbl[14] = mkv(0, 3'd0, 32'h2001, 0, 32'h0000FF00,
                  32'hFFFFFFFF, 0, 0, 0, 4'h0, 2'd0);

    rst = 1'b1;
    req_valid = 1'b1;
    req_wr = 1'b0;
    req_func = 3'd4;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    flush = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    #1 chk("rst_stall_gated", 32'(stall), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_exc", 32'({exc_adel, exc_ades}), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_badvaddr", badvaddr, 32'd0);

    foreach (tbl[i]) do_op(tbl[i], 0, 0, 0, 0);

    // addr_ok withheld, request withdrawn by flush
    @(negedge clk);
    set_req(0, 3'd4, 32'h9000, 0);
    #1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) flush = 1'b1;
      #1;
      chk("hold_req", 32'(data_req), 32'd1);
      chk("hold_addr", data_addr, 32'h9000);
      chk("hold_stall", 32'(stall), 32'(k < 3));
    end
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    #1 chk("wd_req", 32'(data_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("wd_resp", 32'(resp_valid), 32'd0);
    end

    // flush after address accepted: data drained, no response
    @(negedge clk);
    set_req(0, 3'd4, 32'hA000, 0);
    #1;
    @(negedge clk);
    data_addr_ok = 1'b1;
    #1 chk("dr_req", 32'(data_req), 32'd1);
    @(negedge clk);
    data_addr_ok = 1'b0;
    flush = 1'b1;
    #1 chk("dr_flush_stall", 32'(stall), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        flush = 1'b0;
        set_req(0, 3'd4, 32'hB000, 0);
      end
      data_data_ok = (k == 5);
      data_rdata = $urandom;
      #1;
      chk("dr_noreq", 32'(data_req), 32'd0);
      chk("dr_noresp", 32'(resp_valid), 32'd0);
      chk("dr_stall", 32'(stall), 32'd1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    bus_idle();
    #1 chk("dr_end_resp", 32'(resp_valid), 32'd0);
    do_op(mkv(0, 3'd4, 32'hB000, 0, 32'h0BADF00D,
              32'h0BADF00D, 0, 0, 0, 4'h0, 2'd2), 0, 1, 0, 0);

    // reset while waiting for data
    @(negedge clk);
    set_req(0, 3'd4, 32'hC000, 0);
    #1;
    @(negedge clk);
    data_addr_ok = 1'b1;
    #1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    rst = 1'b1;
    #1 chk("mid_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("mr_req", 32'(data_req), 32'd0);
    chk("mr_wstrb", 32'(data_wstrb), 32'd0);
    chk("mr_rdata", resp_rdata, 32'd0);
    chk("mr_badvaddr", badvaddr, 32'd0);
    chk("mr_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    data_data_ok = 1'b1;
    #1;
    @(negedge clk);
    bus_idle();
    #1 chk("mr_stale", 32'(resp_valid), 32'd0);
    do_op(tbl[1], 1, 2, 1, 0);

    // flush in completion cycle hides result and exceptions
    do_op(tbl[6], 0, 0, 0, 1);
    do_op(tbl[4], 0, 0, 0, 1);
    do_op(tbl[0], 2, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 7));
      if (rw && (rf == 3'd1 || rf == 3'd3)) rf = rf - 3'd1;
      rv = model(rw, rf, $urandom, $urandom, $urandom);
      do_op(rv, $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
